// File: rtl/accel_layer_sequencer.sv
// rtl/accel_layer_sequencer.sv - per-layer descriptor queue and accelerator configuration sequencer
//
// Queues convolution-layer descriptors. For each one it holds the accelerator
// in reset, streams the ten configuration words (custom opcode, rd 0..9), then
// the trigger word (rd 31), and waits for accel_done or a timeout.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   desc_valid/ready  descriptor push handshake
//   desc_data[128:0]  packed descriptor, image_dim in the LSBs
//   instruction[31:0] instruction word to the accelerator (NOP when idle)
//   accel_rst_ext     accelerator external reset
//   accel_done        accelerator finished the current layer (only seen in WAIT)
//   layer_done        one-cycle completion pulse
//   layer_timeout     one-cycle abort pulse
//   busy              sequencer is not IDLE
//   fifo_count        queued descriptors
//   layers_completed  wrapping completed-layer counter
module accel_layer_sequencer #(
    parameter int DEPTH          = 4,
    parameter int ARST_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           desc_valid,
    output logic                           desc_ready,
    input  logic [128:0]                   desc_data,
    output logic [31:0]                    instruction,
    output logic                           accel_rst_ext,
    input  logic                           accel_done,
    output logic                           layer_done,
    output logic                           layer_timeout,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic [15:0]                    layers_completed
);

    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [6:0]  OPC       = 7'b0001011;
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] ARST_LAST = 32'(ARST_CYCLES - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {S_IDLE, S_ARST, S_CFG, S_TRIG, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [31:0]     cnt_q, cnt_d;       // ARST length and WAIT timer share one counter
    logic [128:0]    work_q, work_d;
    logic [15:0]     completed_d;
    logic            done_d, tmo_d;
    logic [19:0]     imm20;
    logic [31:0]     instr_d;

    logic [128:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign push       = desc_valid && desc_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign count_d    = count_q + CW'(push) - CW'(pop);
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= desc_data;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        completed_d = layers_completed;
        done_d      = 1'b0;
        tmo_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    work_d  = mem[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_ARST;
                end
            end
            S_ARST: begin
                if (cnt_q == ARST_LAST) begin
                    idx_d   = '0;
                    state_d = S_CFG;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CFG: begin
                if (idx_q == 4'd9) state_d = S_TRIG;
                else               idx_d   = idx_q + 4'd1;
            end
            S_TRIG: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a coincident timeout
                if (accel_done) begin
                    done_d      = 1'b1;
                    completed_d = layers_completed + 16'd1;
                    state_d     = S_IDLE;
                end else if (TMO_EN && cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so that each cycle's
    // outputs belong to the state active in that cycle.
    always_comb begin
        imm20 = '0;
        case (idx_d)
            4'd0: imm20 = {12'b0, work_d[7:0]};
            4'd1: imm20 = {11'b0, work_d[16:8]};
            4'd2: imm20 = {1'b0,  work_d[35:17]};
            4'd3: imm20 = {1'b0,  work_d[54:36]};
            4'd4: imm20 = {1'b0,  work_d[73:55]};
            4'd5: imm20 = {18'b0, work_d[75:74]};
            4'd6: imm20 = {17'b0, work_d[78:76]};
            4'd7: imm20 = {7'b0,  work_d[91:79]};
            4'd8: imm20 = {2'b0,  work_d[109:92]};
            4'd9: imm20 = {1'b0,  work_d[128:110]};
            default: imm20 = '0;
        endcase
        case (state_d)
            S_CFG:   instr_d = {imm20, 1'b0, idx_d, OPC};
            S_TRIG:  instr_d = {20'b0, 5'b11111, OPC};
            default: instr_d = NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            cnt_q            <= '0;
            work_q           <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            desc_ready       <= 1'b1;
            instruction      <= NOP;
            accel_rst_ext    <= 1'b1;
            layer_done       <= 1'b0;
            layer_timeout    <= 1'b0;
            busy             <= 1'b0;
            layers_completed <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            work_q           <= work_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q          <= count_d;
            desc_ready       <= (count_d < CW'(DEPTH));
            instruction      <= instr_d;
            accel_rst_ext    <= (state_d == S_IDLE) || (state_d == S_ARST);
            layer_done       <= done_d;
            layer_timeout    <= tmo_d;
            busy             <= (state_d != S_IDLE);
            layers_completed <= completed_d;
        end
    end

endmodule

// File: doc/accel_layer_sequencer.md
Name: accel_layer_sequencer

Overview:
- Upstream command stage for the accelerator. Queues per-layer convolution descriptors.
- For each descriptor, holds the accelerator in reset, then emits the configuration instruction stream (custom opcode 7'b0001011, rd 0..9) and the trigger (rd 31).
- Waits for the accelerator's done, then reports completion or timeout.
- Drives the accelerator's instruction and rst_ext inputs and consumes its accel_done.

Parameters:
- DEPTH, 4: descriptor FIFO entries (power of two, at least 2).
- ARST_CYCLES, 2: cycles accel_rst_ext is held high before configuration (at least 1).
- TIMEOUT_CYCLES, 1048576: maximum cycles spent in WAIT; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- desc_valid  in  1  descriptor push request.
- desc_ready  out  1  FIFO can accept a descriptor.
- desc_data  in  129  packed descriptor, LSB first: image_dim[7:0], image_depth[16:8], image_offset[35:17], filter_offset[54:36], output_offset[73:55], filter_halfsize[75:74], filter_stride[78:76], filter_length[91:79], filter_bias[109:92], accel_interrupt[128:110].
- instruction  out  32  instruction word to the accelerator.
- accel_rst_ext  out  1  accelerator external reset.
- accel_done  in  1  accelerator finished the current layer.
- layer_done  out  1  one-cycle pulse when a layer completes.
- layer_timeout  out  1  one-cycle pulse when a layer is aborted by the timeout.
- busy  out  1  high whenever the state is not IDLE.
- fifo_count  out  $clog2(DEPTH+1)  number of queued descriptors.
- layers_completed  out  16  count of completed layers; wraps at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, FIFO empty, fifo_count 0, desc_ready 1;
  - instruction 32'h00000013 (NOP);
  - accel_rst_ext 1;
  - layer_done, layer_timeout and busy 0; layers_completed 0.
- Reset mid-layer abandons the layer without a pulse and discards the queue.
- FIFO:
  - Push when desc_valid && desc_ready; desc_ready = (fifo_count < DEPTH).
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - No push when full, no pop when empty.
  - Pointers wrap modulo DEPTH. Order is FIFO.
- All outputs are registered and Moore-style: the value in a cycle reflects the state active in that cycle.
- States:
  - IDLE: instruction NOP, accel_rst_ext 1. If fifo_count > 0: pop the head into the working register, go to ARST.
  - ARST: accel_rst_ext 1, instruction NOP, for ARST_CYCLES cycles, then go to CFG with idx 0.
  - CFG: accel_rst_ext 0. instruction = {imm20, rd=idx[4:0], 7'b0001011}, where imm20 is the zero-extended field for idx. Field map: 0 image_dim, 1 image_depth, 2 image_offset, 3 filter_offset, 4 output_offset, 5 filter_halfsize, 6 filter_stride, 7 filter_length, 8 filter_bias, 9 accel_interrupt. One word per cycle; after idx 9, go to TRIG.
  - TRIG: instruction = {20'b0, 5'b11111, 7'b0001011} for exactly one cycle, then go to WAIT with the timer cleared.
  - WAIT: instruction NOP, accel_rst_ext 0.
    - accel_done high: layer_done pulse next cycle, layers_completed += 1, go to IDLE.
    - Otherwise, if TIMEOUT_CYCLES != 0 and the timer reaches TIMEOUT_CYCLES-1: layer_timeout pulse next cycle, go to IDLE; the counter does not change.
    - If done and timeout coincide, done wins.
- accel_done is ignored in every state except WAIT.
- Pushes are accepted in every state. Back-to-back layers pass through IDLE for one cycle, with accel_rst_ext high.
- Latency with defaults, counting from the cycle after the push edge, on an empty and idle block:
  - cycle 0: IDLE pop;
  - cycles 1-2: ARST;
  - cycles 3-12: CFG rd 0..9;
  - cycle 13: TRIG;
  - cycle 14: WAIT begins.

Test Plan:
- Reset: hold rst_n low, then release → instruction 32'h00000013, accel_rst_ext 1, desc_ready 1, busy 0, layers_completed 0.
- Single layer, image_dim 8'd32, image_offset 19'h1000, bias 18'h3FFFF:
  - → cycle 3 instruction 32'h0002000B;
  - → cycle 5 instruction {20'h01000, 5'd2, 7'h0B} = 32'h0100010B;
  - → cycle 11 shows bias zero-extended with rd 8;
  - → cycle 13 instruction 32'h00000F8B;
  - → accel_done 20 cycles later gives layer_done 1 for one cycle, layers_completed 1.
- FIFO full with DEPTH=4: push 5 descriptors back-to-back while busy → the 5th is stalled (desc_ready 0, fifo_count 4). Layers are issued in push order, each preceded by at least 2 cycles of accel_rst_ext=1.
- Timeout with TIMEOUT_CYCLES=16 and accel_done never asserted → layer_timeout pulses 16 cycles after WAIT entry, layers_completed unchanged, state returns to IDLE.
- Stray done: accel_done high during CFG, then low in WAIT → no layer_done; completion occurs only on a later done while in WAIT.
- Async reset asserted during CFG idx 5 → outputs take their reset values immediately, without waiting for a clock edge; the queued descriptors are lost.
